// File: rtl/cache_pkg.sv
// Shared types and constants for the trace-driven set-associative cache model.
package cache_pkg;

  localparam int CNT_W  = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    ACC_READ  = 2'd0,
    ACC_WRITE = 2'd1,
    ACC_INVAL = 2'd2,
    ACC_IDLE  = 2'd3
  } access_e;

  // Tag is kept full-width (address shifted down) so any geometry fits.
  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [ADDR_W-1:0] tag;
  } line_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cache_repl.sv
// Replacement state update and victim choice for one set (true LRU or MRU-bit pseudo-LRU).
module cache_repl
  import cache_pkg::*;
#(
  parameter int num_ways           = 8,
  parameter int replacement_policy = 0,
  localparam int WW                = clog2_min1(num_ways)
) (
  input  logic [num_ways-1:0][WW-1:0] state_i,
  input  logic [WW-1:0]               touch_way_i,
  output logic [num_ways-1:0][WW-1:0] state_o,
  output logic [WW-1:0]               victim_o
);

  logic [num_ways-1:0] mru;
  logic                found;

  always_comb begin
    state_o  = state_i;
    victim_o = '0;
    mru      = '0;
    found    = 1'b0;
    if (replacement_policy == 0) begin
      // Ages form a permutation of 0..num_ways-1; the oldest has age num_ways-1.
      for (int w = 0; w < num_ways; w++) begin
        if (state_i[w] < state_i[touch_way_i]) state_o[w] = state_i[w] + WW'(1);
        if (state_i[w] == WW'(num_ways - 1)) victim_o = WW'(w);
      end
      state_o[touch_way_i] = '0;
    end else begin
      // MRU bit lives in bit 0 of each way's entry.
      for (int w = 0; w < num_ways; w++) begin
        mru[w] = state_i[w][0];
        if (!state_i[w][0] && !found) begin
          victim_o = WW'(w);
          found    = 1'b1;
        end
      end
      mru[touch_way_i] = 1'b1;
      if (&mru) begin
        mru              = '0;
        mru[touch_way_i] = 1'b1;
      end
      for (int w = 0; w < num_ways; w++) state_o[w][0] = mru[w];
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// Tag/valid/dirty-only write-back, write-allocate cache model with access statistics.
// One access per clock, no handshake: Access_type/Hex_address are consumed every rising edge.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int num_sets           = 32,
  parameter int num_ways           = 8,
  parameter int line_size          = 64,
  parameter int replacement_policy = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       Access_type,
  input  logic [31:0]      Hex_address,
  output logic [CNT_W-1:0] total_number_of_cache_accesses,
  output logic [CNT_W-1:0] number_of_cache_reads,
  output logic [CNT_W-1:0] number_of_cache_writes,
  output logic [CNT_W-1:0] number_of_invalidates,
  output logic [CNT_W-1:0] number_of_cache_hits,
  output logic [CNT_W-1:0] number_of_cache_misses,
  output logic [CNT_W-1:0] number_of_evictions,
  output logic [CNT_W-1:0] number_of_writebacks
);

  localparam int OFF_W = $clog2(line_size);
  localparam int IDX_W = $clog2(num_sets);
  localparam int SW    = clog2_min1(num_sets);
  localparam int WW    = clog2_min1(num_ways);

  line_t                       lines_q [num_sets][num_ways];
  logic [num_ways-1:0][WW-1:0] repl_q  [num_sets];
  logic [num_ways-1:0][WW-1:0] repl_next;

  logic [CNT_W-1:0] total_q, reads_q, writes_q, inval_q, hits_q, misses_q, evict_q, wb_q;

  access_e           acc;
  logic [SW-1:0]     idx;
  logic [ADDR_W-1:0] tag;
  logic              hit, inv_found, is_write;
  logic [WW-1:0]     hit_way, inv_way, pol_victim, alloc_way, touch_way;
  line_t             victim_line, hit_line;

  assign acc      = access_e'(Access_type);
  assign is_write = (acc == ACC_WRITE);
  assign idx      = SW'((Hex_address >> OFF_W) & ADDR_W'(num_sets - 1));
  assign tag      = Hex_address >> (OFF_W + IDX_W);

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < num_ways; w++) begin
      if (lines_q[idx][w].valid && (lines_q[idx][w].tag == tag) && !hit) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!lines_q[idx][w].valid && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
    // Free ways are always filled lowest-first before the policy is consulted.
    alloc_way   = inv_found ? inv_way : pol_victim;
    touch_way   = hit ? hit_way : alloc_way;
    victim_line = lines_q[idx][alloc_way];
    hit_line    = lines_q[idx][hit_way];
  end

  cache_repl #(
    .num_ways          (num_ways),
    .replacement_policy(replacement_policy)
  ) u_repl (
    .state_i    (repl_q[idx]),
    .touch_way_i(touch_way),
    .state_o    (repl_next),
    .victim_o   (pol_victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < num_sets; s++) begin
        for (int w = 0; w < num_ways; w++) begin
          lines_q[s][w] <= '0;
          repl_q[s][w]  <= (replacement_policy == 0) ? WW'(w) : '0;
        end
      end
      total_q  <= '0;
      reads_q  <= '0;
      writes_q <= '0;
      inval_q  <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      evict_q  <= '0;
      wb_q     <= '0;
    end else begin
      case (acc)
        ACC_READ, ACC_WRITE: begin
          total_q     <= total_q + CNT_W'(1);
          if (is_write) writes_q <= writes_q + CNT_W'(1);
          else          reads_q  <= reads_q + CNT_W'(1);
          repl_q[idx] <= repl_next;
          if (hit) begin
            hits_q <= hits_q + CNT_W'(1);
            if (is_write) lines_q[idx][hit_way].dirty <= 1'b1;
          end else begin
            misses_q <= misses_q + CNT_W'(1);
            if (victim_line.valid) evict_q <= evict_q + CNT_W'(1);
            if (victim_line.valid && victim_line.dirty) wb_q <= wb_q + CNT_W'(1);
            lines_q[idx][alloc_way] <= '{valid: 1'b1, dirty: is_write, tag: tag};
          end
        end
        ACC_INVAL: begin
          total_q <= total_q + CNT_W'(1);
          inval_q <= inval_q + CNT_W'(1);
          if (hit) begin
            if (hit_line.dirty) wb_q <= wb_q + CNT_W'(1);
            lines_q[idx][hit_way].valid <= 1'b0;
            lines_q[idx][hit_way].dirty <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign total_number_of_cache_accesses = total_q;
  assign number_of_cache_reads          = reads_q;
  assign number_of_cache_writes         = writes_q;
  assign number_of_invalidates          = inval_q;
  assign number_of_cache_hits           = hits_q;
  assign number_of_cache_misses         = misses_q;
  assign number_of_evictions            = evict_q;
  assign number_of_writebacks           = wb_q;

endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench: true-LRU and MRU-bit instances share one directed trace.
module tb_set_assoc_cache;
  import cache_pkg::*;

  localparam logic [1:0] RD = 2'd0, WR = 2'd1, INV = 2'd2, IDL = 2'd3;

  typedef struct {
    bit               chk;
    string            nm;
    logic [7:0][31:0] e0;
    logic [7:0][31:0] e1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  acc_t = IDL;
  logic [31:0] addr = '0;
  logic [31:0] c0 [8];
  logic [31:0] c1 [8];

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    n_cmp = 0;
  int    n_fail = 0;
  string cnt_name [8] = '{"total", "reads", "writes", "invals", "hits", "misses", "evicts", "wbacks"};

  always #5 clk = ~clk;

  set_assoc_cache #(.replacement_policy(0)) u_lru (
    .clk(clk), .rst_n(rst_n), .Access_type(acc_t), .Hex_address(addr),
    .total_number_of_cache_accesses(c0[0]), .number_of_cache_reads(c0[1]),
    .number_of_cache_writes(c0[2]), .number_of_invalidates(c0[3]),
    .number_of_cache_hits(c0[4]), .number_of_cache_misses(c0[5]),
    .number_of_evictions(c0[6]), .number_of_writebacks(c0[7])
  );

  set_assoc_cache #(.replacement_policy(1)) u_mru (
    .clk(clk), .rst_n(rst_n), .Access_type(acc_t), .Hex_address(addr),
    .total_number_of_cache_accesses(c1[0]), .number_of_cache_reads(c1[1]),
    .number_of_cache_writes(c1[2]), .number_of_invalidates(c1[3]),
    .number_of_cache_hits(c1[4]), .number_of_cache_misses(c1[5]),
    .number_of_evictions(c1[6]), .number_of_writebacks(c1[7])
  );

  function automatic logic [7:0][31:0] pk(input int t, r, w, i, h, m, e, b);
    logic [7:0][31:0] v;
    v[0] = t; v[1] = r; v[2] = w; v[3] = i;
    v[4] = h; v[5] = m; v[6] = e; v[7] = b;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0][31:0] e0, input logic [7:0][31:0] e1);
    for (int i = 0; i < 8; i++) begin
      chk({nm, " lru ", cnt_name[i]}, c0[i], e0[i]);
      chk({nm, " mru ", cnt_name[i]}, c1[i], e1[i]);
    end
  endtask

  // Monitor: every driven access is answered one edge later.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.chk) chk_all(mon_e.nm, mon_e.e0, mon_e.e1);
    end
  end

  task automatic push(input logic [1:0] t, input logic [31:0] a, input bit c, input string nm,
                      input logic [7:0][31:0] e0, input logic [7:0][31:0] e1);
    exp_t e;
    @(negedge clk);
    acc_t = t;
    addr  = a;
    e.chk = c; e.nm = nm; e.e0 = e0; e.e1 = e1;
    exp_q.push_back(e);
  endtask

  task automatic acc(input logic [1:0] t, input logic [31:0] a);
    push(t, a, 1'b0, "", '0, '0);
  endtask

  task automatic acc_chk(input logic [1:0] t, input logic [31:0] a, input string nm,
                         input logic [7:0][31:0] v);
    push(t, a, 1'b1, nm, v, v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    acc_t = IDL;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_all("reset_state", '0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    acc_chk(RD, 32'h0, "rep_rd1", pk(1, 1, 0, 0, 0, 1, 0, 0));
    acc_chk(RD, 32'h0, "rep_rd2", pk(2, 2, 0, 0, 1, 1, 0, 0));

    do_reset();
    acc(WR, 32'h40);
    acc_chk(RD, 32'h7F, "same_line", pk(2, 1, 1, 0, 1, 1, 0, 0));

    do_reset();
    for (int k = 0; k < 8; k++) acc(RD, k * 32'h800);
    acc_chk(RD, 32'h4000, "clean_evict", pk(9, 9, 0, 0, 0, 9, 1, 0));
    acc_chk(RD, 32'h0, "clean_evict2", pk(10, 10, 0, 0, 0, 10, 2, 0));

    do_reset();
    for (int k = 0; k < 8; k++) acc(WR, k * 32'h800);
    acc_chk(WR, 32'h4000, "dirty_evict", pk(9, 0, 9, 0, 0, 9, 1, 1));

    do_reset();
    acc(WR, 32'h100);
    acc_chk(INV, 32'h100, "inval_dirty", pk(2, 0, 1, 1, 0, 1, 0, 1));
    acc_chk(RD, 32'h100, "inval_reread", pk(3, 1, 1, 1, 0, 2, 0, 1));
    acc_chk(INV, 32'h200, "inval_absent", pk(4, 1, 1, 2, 0, 2, 0, 1));
    acc_chk(IDL, 32'h100, "idle_noop", pk(4, 1, 1, 2, 0, 2, 0, 1));

    do_reset();
    acc(RD, 32'h0);
    acc(WR, 32'h0);
    acc_chk(INV, 32'h0, "write_hit_dirty", pk(3, 1, 1, 1, 1, 1, 0, 1));

    do_reset();
    for (int k = 0; k < 8; k++) acc(RD, k * 32'h800);
    for (int k = 0; k < 7; k++) acc(RD, k * 32'h800);
    acc(RD, 32'h4000);
    push(RD, 32'h0, 1'b1, "policy_cmp", pk(17, 17, 0, 0, 8, 9, 1, 0), pk(17, 17, 0, 0, 7, 10, 2, 0));

    do_reset();
    acc(RD, 32'h0);
    acc(WR, 32'h800);
    acc_chk(RD, 32'h0, "pre_reset", pk(3, 2, 1, 0, 1, 2, 0, 0));
    @(negedge clk);
    #2;
    acc_t = RD;
    addr  = 32'h0;
    rst_n = 1'b0;
    #1 chk_all("mid_reset", '0, '0);
    @(posedge clk);
    #1 chk_all("reset_drop", '0, '0);
    @(negedge clk);
    acc_t = IDL;
    rst_n = 1'b1;
    acc_chk(RD, 32'h0, "post_reset", pk(1, 1, 0, 0, 0, 1, 0, 0));
    acc(IDL, 32'h0);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
